// File: rtl/scs_pkg.sv
// scs_pkg: shared state encoding, checksum width and weight rule for the SCS blocks.
package scs_pkg;
  localparam int CSUM_W = 16;
  typedef enum logic [1:0] {IDLE, RD_WAIT, PRESENT, DONE} state_t;
  function automatic logic [CSUM_W-1:0] scs_weight(input logic [7:0] b, input logic [1:0] idx);
    return CSUM_W'(b) << idx;
  endfunction
endpackage

// File: rtl/scs_checksum_acc.sv
// scs_checksum_acc: running SCS checksum, 16-bit wrapping sum of byte << index[1:0].
module scs_checksum_acc
  import scs_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              byte_valid,
  input  logic [7:0]        byte_in,
  input  logic [1:0]        index,
  output logic [CSUM_W-1:0] sum
);
  logic [CSUM_W-1:0] sum_q, sum_d;
  always_comb sum_d = clear ? '0 : byte_valid ? sum_q + scs_weight(byte_in, index) : sum_q;
  always_ff @(posedge clock) sum_q <= reset ? '0 : sum_d;
  assign sum = sum_q;
endmodule

// File: rtl/scs_frame_tx.sv
// scs_frame_tx: reads payload plus stored checksum back from RAM and streams it on valid/ready.
// Define SCS_FRAME_TX_VERIFY_EN to recompute the checksum in flight and flag mismatches.
module scs_frame_tx
  import scs_pkg::*;
#(
  parameter int RAM_WIDTH      = 8,
  parameter int RAM_ADDR_BITS  = 8,
  parameter int MEM_RD_LATENCY = 2
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     start,
  input  logic [15:0]              payload_len,
  output logic [RAM_ADDR_BITS-1:0] mem_address,
  input  logic [RAM_WIDTH-1:0]     mem_output,
  output logic [RAM_WIDTH-1:0]     tx_data,
  output logic                     tx_valid,
  input  logic                     tx_ready,
  output logic                     tx_last,
  output logic                     busy,
  output logic                     done,
  output logic                     length_error
`ifdef SCS_FRAME_TX_VERIFY_EN
  ,
  output logic                     checksum_error
`endif
);
  localparam logic [16:0] MAX_FLEN = 17'(1) << RAM_ADDR_BITS;
  state_t                 state_q, state_d;
  logic [16:0]            flen_q, flen_d, idx_q, idx_d, new_flen;
  logic [1:0]             wait_q, wait_d;
  logic [RAM_WIDTH-1:0]   data_q, data_d;
  logic                   valid_q, valid_d, last_q, last_d, lerr_q, lerr_d;
  logic                   accept, hs;
  assign new_flen = {1'b0, payload_len} + 17'd2;
  assign accept   = state_q == IDLE && start && new_flen <= MAX_FLEN;
  assign hs       = state_q == PRESENT && tx_ready;
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      flen_q  <= '0;
      idx_q   <= '0;
      wait_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
      lerr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      flen_q  <= flen_d;
      idx_q   <= idx_d;
      wait_q  <= wait_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      last_q  <= last_d;
      lerr_q  <= lerr_d;
    end
  end
  always_comb begin
    state_d = state_q;
    flen_d  = flen_q;
    idx_d   = idx_q;
    wait_d  = wait_q;
    data_d  = data_q;
    valid_d = valid_q;
    last_d  = last_q;
    lerr_d  = state_q == IDLE && start && new_flen > MAX_FLEN;
    case (state_q)
      IDLE: if (accept) begin
        state_d = RD_WAIT;
        flen_d  = new_flen;
        idx_d   = '0;
        wait_d  = '0;
      end
      RD_WAIT: if (wait_q == 2'(MEM_RD_LATENCY - 1)) begin
        state_d = PRESENT;
        data_d  = mem_output;
        valid_d = 1'b1;
        last_d  = idx_q == flen_q - 17'd1;
        wait_d  = '0;
      end else wait_d = wait_q + 2'd1;
      PRESENT: if (hs) begin
        valid_d = 1'b0;
        state_d = last_q ? DONE : RD_WAIT;
        last_d  = 1'b0;
        idx_d   = last_q ? '0 : idx_q + 17'd1;
      end
      DONE: state_d = IDLE;
    endcase
  end
  always_comb begin
    mem_address  = idx_q[RAM_ADDR_BITS-1:0];
    tx_data      = data_q;
    tx_valid     = valid_q;
    tx_last      = last_q;
    busy         = state_q == RD_WAIT || state_q == PRESENT;
    done         = state_q == DONE;
    length_error = lerr_q;
  end
`ifdef SCS_FRAME_TX_VERIFY_EN
  logic [CSUM_W-1:0] sum;
  logic [7:0]        hi_q, hi_d;
  logic              cerr_q, cerr_d;
  scs_checksum_acc u_acc (
    .clock      (clock),
    .reset      (reset),
    .clear      (accept),
    .byte_valid (hs && idx_q < flen_q - 17'd2),
    .byte_in    (data_q[7:0]),
    .index      (idx_q[1:0]),
    .sum        (sum)
  );
  // The last handshake carries the low checksum byte; the high byte was held one beat earlier.
  always_comb begin
    hi_d   = hs && idx_q == flen_q - 17'd2 ? data_q[7:0] : hi_q;
    cerr_d = accept ? 1'b0 : hs && last_q ? {hi_q, data_q[7:0]} != sum : cerr_q;
  end
  always_ff @(posedge clock) begin
    hi_q   <= reset ? '0 : hi_d;
    cerr_q <= reset ? 1'b0 : cerr_d;
  end
  assign checksum_error = cerr_q;
`endif
endmodule

// File: tb/tb_scs_frame_tx.sv
// tb_scs_frame_tx: scoreboard bench; stimulus queues expected bytes, a monitor pops them on handshakes.
module tb_scs_frame_tx;
  logic       clock = 0, reset = 1, start = 0, tx_ready = 1;
  logic [15:0] payload_len = 0;
  logic [7:0] mem_address, mem_output, tx_data;
  logic       tx_valid, tx_last, busy, done, length_error;
`ifdef SCS_FRAME_TX_VERIFY_EN
  logic       checksum_error;
`endif
  scs_frame_tx #(.RAM_WIDTH(8), .RAM_ADDR_BITS(8), .MEM_RD_LATENCY(2)) dut (
    .clock(clock), .reset(reset), .start(start), .payload_len(payload_len),
    .mem_address(mem_address), .mem_output(mem_output),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_last(tx_last),
    .busy(busy), .done(done), .length_error(length_error)
`ifdef SCS_FRAME_TX_VERIFY_EN
    , .checksum_error(checksum_error)
`endif
  );
  always #5 clock = ~clock;

  // Latency-2 RAM: address seen on one edge, data sampled by the DUT on the next.
  logic [7:0] ram [256];
  always @(posedge clock) mem_output <= ram[mem_address];

  int errors = 0, checks = 0;
  int done_cnt = 0, lerr_cnt = 0, valid_cnt = 0, busy_cnt = 0, hs_cnt = 0;
  logic [8:0] exp_q [$];
  logic [7:0] last_addr = 0;
  bit         ready_toggle = 0, exp_cerr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clock);
    #1 tx_ready = ready_toggle ? ~tx_ready : 1'b1;
  end

  initial begin : monitor
    bit held = 0;
    logic [8:0] held_v = 0;
    forever begin
      @(negedge clock);
      if (reset) held = 0;
      else begin
        if (held) chk("stall_stable", {tx_valid, tx_last, tx_data}, {1'b1, held_v});
        held   = tx_valid && !tx_ready;
        held_v = {tx_last, tx_data};
        if (tx_valid && tx_ready) begin
          hs_cnt++;
          if (tx_last) last_addr = mem_address;
          if (exp_q.size() == 0) chk("unexpected_byte", {tx_last, tx_data}, 9'h1ff);
          else chk("byte", {tx_last, tx_data}, exp_q.pop_front());
        end
        if (done) begin
          done_cnt++;
`ifdef SCS_FRAME_TX_VERIFY_EN
          chk("checksum_error", checksum_error, exp_cerr);
`endif
        end
        if (length_error) lerr_cnt++;
        if (tx_valid) valid_cnt++;
        if (busy) busy_cnt++;
      end
    end
  end

  task automatic load_csum(input int plen);
    logic [15:0] s = 0;
    for (int i = 0; i < plen; i++) s += 16'(ram[i]) << (i % 4);
    ram[plen]     = s[15:8];
    ram[plen + 1] = s[7:0];
  endtask

  task automatic run_frame(input int plen, input bit tog, input bit mid_start, input bit done_start, input bit cerr);
    int d0, lat;
    bit seen = 0;
    ready_toggle = tog;
    exp_cerr = cerr;
    for (int i = 0; i < plen + 2; i++) exp_q.push_back({i == plen + 1, ram[i]});
    d0 = done_cnt;
    payload_len = 16'(plen);
    start = 1;
    @(posedge clock);
    #1 start = 0;
    lat = 0;
    do begin @(negedge clock); lat++; end while (!tx_valid && lat < 50);
    chk("first_valid_latency", lat, 3);
    chk("busy_in_frame", busy, 1);
    if (mid_start) begin
      start = 1;
      @(posedge clock);
      #1 start = 0;
    end
    for (int i = 0; i < 4000; i++) begin
      @(negedge clock);
      if (done) begin seen = 1; break; end
    end
    chk("done_seen", seen, 1);
    if (done_start) begin
      start = 1;
      @(posedge clock);
      #1 start = 0;
      repeat (5) @(negedge clock);
      chk("done_cycle_start_ignored", {busy, tx_valid}, 0);
    end
    repeat (2) @(negedge clock);
    chk("done_pulses", done_cnt - d0, 1);
    chk("queue_drained", exp_q.size(), 0);
    chk("last_address", last_addr, plen + 1);
    chk("busy_after_done", busy, 0);
`ifdef SCS_FRAME_TX_VERIFY_EN
    chk("checksum_error_held", checksum_error, cerr);
`endif
    ready_toggle = 0;
  endtask

  initial begin
    int l0, v0, b0, d0, h0;
    for (int i = 0; i < 256; i++) ram[i] = 0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_outputs", {tx_valid, busy, done, length_error, tx_last, mem_address, tx_data}, 0);
    @(posedge clock);
    #1 reset = 0;

    {ram[0], ram[1], ram[2], ram[3], ram[4]} = {8'h01, 8'h02, 8'h03, 8'h00, 8'h11};
    run_frame(3, 0, 0, 0, 0);

    for (int i = 0; i < 5; i++) ram[i] = 8'hff;
    {ram[5], ram[6]} = {8'h0f, 8'hf0};
    run_frame(5, 1, 0, 0, 0);

    {ram[0], ram[1]} = {8'h00, 8'h00};
    run_frame(0, 0, 0, 1, 0);

    l0 = lerr_cnt; v0 = valid_cnt; b0 = busy_cnt;
    payload_len = 16'd255;
    start = 1;
    @(posedge clock);
    #1 start = 0;
    repeat (6) @(negedge clock);
    chk("length_error_pulse", lerr_cnt - l0, 1);
    chk("length_error_no_valid", valid_cnt - v0, 0);
    chk("length_error_no_busy", busy_cnt - b0, 0);

    for (int i = 0; i < 254; i++) ram[i] = 8'(i * 7 + 3);
    load_csum(254);
    run_frame(254, 0, 0, 0, 0);

    {ram[0], ram[1], ram[2], ram[3], ram[4]} = {8'h01, 8'h02, 8'h03, 8'h00, 8'h11};
    for (int i = 0; i < 5; i++) exp_q.push_back({i == 4, ram[i]});
    d0 = done_cnt; h0 = hs_cnt;
    payload_len = 16'd3;
    start = 1;
    @(posedge clock);
    #1 start = 0;
    for (int i = 0; i < 200 && hs_cnt < h0 + 2; i++) @(negedge clock);
    chk("abort_two_bytes", hs_cnt - h0, 2);
    @(posedge clock);
    #1 reset = 1;
    exp_q.delete();
    @(posedge clock);
    @(negedge clock);
    chk("reset_midframe_outputs", {tx_valid, busy, done, length_error, tx_last, mem_address, tx_data}, 0);
    @(posedge clock);
    #1 reset = 0;
    repeat (4) @(negedge clock);
    chk("abort_no_done", done_cnt - d0, 0);
    run_frame(3, 0, 1, 0, 0);

    {ram[3], ram[4]} = {8'h00, 8'h12};
    run_frame(3, 1, 1, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/scs_frame_tx.md
Name: scs_frame_tx

Overview:
- Downstream stage of the SCS checksum engine.
- After the engine has written the 16-bit checksum behind the payload in the shared byte RAM, this block reads the frame back and streams it out on a byte valid/ready interface.
- Frame on the wire: payload bytes 0..payload_len-1, then checksum high byte (address payload_len), then checksum low byte (address payload_len+1).
- Read-only RAM client; the RAM port is muxed to it by the top level while busy is high.

Parameters:
- RAM_WIDTH, 8, RAM data width; the stream byte width equals this.
- RAM_ADDR_BITS, 8, RAM address width.
- MEM_RD_LATENCY, 2, clocks from a mem_address change to valid mem_output. Legal range 1..3.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle pulse; typically driven by the checksum engine's work_complete. Ignored while busy.
- payload_len  in  16  payload byte count, sampled on the accepted start.
- mem_address  out  RAM_ADDR_BITS  RAM read address.
- mem_output  in  RAM_WIDTH  RAM read data.
- tx_data  out  RAM_WIDTH  stream byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready.
- tx_last  out  1  high with the final byte (checksum low byte).
- busy  out  1  high from the accepted start until the DONE state.
- done  out  1  one-cycle pulse after the last byte is accepted.
- length_error  out  1  one-cycle pulse; the frame does not fit in the RAM.

Behaviour:
- Reset: all outputs are 0, state IDLE, internal counters 0. Reset mid-frame aborts immediately; no done pulse is produced.
- Frame length: flen = payload_len + 2, computed 17 bits wide.
- IDLE:
  - On start with flen > 2^RAM_ADDR_BITS: pulse length_error next cycle, stay IDLE, busy stays 0.
  - Otherwise: latch flen, set mem_address = 0 and byte index = 0, busy = 1, go to RD_WAIT.
- RD_WAIT: count MEM_RD_LATENCY clocks, then capture mem_output into the tx_data register; tx_valid = 1; tx_last = (index == flen-1). Go to PRESENT.
- PRESENT:
  - Hold tx_data, tx_valid and tx_last stable until tx_ready.
  - On handshake: if tx_last, drop tx_valid and go to DONE. Else drop tx_valid, increment index and mem_address, go to RD_WAIT.
- Throughput: one byte per (MEM_RD_LATENCY + 1) clocks at best. Prefetch is not required.
- DONE: done = 1 for one cycle, busy = 0, tx_last = 0, then IDLE. A start arriving in the DONE cycle is ignored.
- The first tx_valid appears MEM_RD_LATENCY + 1 clocks after the start cycle.
- tx_ready high while tx_valid is low has no effect. tx_valid never drops without a handshake.
- payload_len = 0 is legal: the frame is two checksum bytes only.
- The address counter never wraps: the length check guarantees the largest address is 2^RAM_ADDR_BITS - 1.
- mem_address is held at 0 while IDLE.

Optional Feature:
- Macro: SCS_FRAME_TX_VERIFY_EN.
- With the macro:
  - While streaming, the block recomputes the SCS checksum over the payload bytes: 16-bit wrapping sum of byte[i] << (i mod 4).
  - It compares the result with the two streamed checksum bytes.
  - Extra output port checksum_error (1 bit) is valid in the done cycle and held until the next accepted start. It is 1 on mismatch. Reset value is 0.
- Without the macro: no port, no accumulator. Behaviour is otherwise identical.

Decomposition:
- Shared package scs_pkg holds:
  - state encoding constants (IDLE, RD_WAIT, PRESENT, DONE);
  - the checksum weight rule (shift = index[1:0]);
  - the checksum width constant, 16.
- One natural sub-module: scs_checksum_acc (clear, byte_valid, byte, index[1:0] -> 16-bit sum). It is shared with the checksum engine and instantiated only under SCS_FRAME_TX_VERIFY_EN.

Test Plan:
- RAM = 01 02 03 00 11, payload_len = 3, tx_ready always 1 -> bytes 01,02,03,00,11; tx_last only on 11; single done pulse; with VERIFY, checksum_error = 0.
- Five 0xFF payload bytes followed by 0F F0, with tx_ready toggling 1/0 every cycle -> five FF bytes, then 0F, F0; data stable while stalled; no byte lost or repeated.
- payload_len = 0, RAM[0..1] = 00 00 -> exactly 2 bytes, tx_last on the second, done asserted.
- RAM_ADDR_BITS = 8, payload_len = 255 -> length_error pulse, no tx_valid, busy stays 0. payload_len = 254 -> 256 bytes streamed, last address FF.
- Reset asserted after byte 2 of 5, then a fresh start -> outputs 0 during reset; new frame restarts at address 0; no done for the aborted frame.
- VERIFY: payload 01 02 03 with stored checksum 00 12 -> checksum_error = 1 in the done cycle. A start pulse while busy is ignored.
